// File: rtl/pc_sequencer_pkg.sv
// Shared types and helpers for the program-counter sequencer.
package pc_pkg;

    // Sequencer operating state
    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        RUN    = 2'd1,
        FAULT  = 2'd2
    } pc_state_t;

    // Sequential fetch increment in bytes
    localparam int PC_STEP = 4;

    // Word alignment test on the two low address bits
    function automatic logic is_aligned(input logic [1:0] addr_lo);
        return (addr_lo == 2'b00);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control and status bundle between the next-PC logic (master) and the sequencer (slave).
interface pc_sequencer_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            redirect_is_call;
    logic            redirect_is_ret;
    logic            trap_req;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_plus4_o;
    logic            pc_valid_o;
    logic            fault_o;
    logic [XLEN-1:0] fault_addr_o;
    logic            ras_empty_o;

    modport master (
        output stall, redirect_valid, redirect_target, redirect_is_call,
               redirect_is_ret, trap_req,
        input  pc_o, pc_plus4_o, pc_valid_o, fault_o, fault_addr_o, ras_empty_o
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, redirect_is_call,
               redirect_is_ret, trap_req,
        output pc_o, pc_plus4_o, pc_valid_o, fault_o, fault_addr_o, ras_empty_o
    );
endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Return-address stack: circular storage with a saturating occupancy count.
// When full, a push silently overwrites the oldest entry.
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [XLEN-1:0] i_push_data,
    output logic [XLEN-1:0] o_top,
    output logic            o_empty
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  r_mem [RAS_DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_ptr_inc;
    logic             w_full;

    assign w_ptr_inc = r_ptr + PTR_W'(1);
    assign w_full    = (r_count == CNT_W'(RAS_DEPTH));
    assign o_top     = r_mem[r_ptr];
    assign o_empty   = (r_count == '0);

    // Push/pop/replace bookkeeping; a simultaneous push+pop on a non-empty stack rewrites the top in place
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_ptr   <= '0;
            r_count <= '0;
        end else if (i_push && i_pop && !o_empty) begin
            r_mem[r_ptr] <= i_push_data;
        end else if (i_push) begin
            r_mem[w_ptr_inc] <= i_push_data;
            r_ptr            <= w_ptr_inc;
            if (!w_full) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (i_pop && !o_empty) begin
            r_ptr   <= r_ptr - PTR_W'(1);
            r_count <= r_count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: warm-up after reset, then sequential fetch with
// trap > redirect > stall priority, return-address prediction and a sticky
// halt on misaligned redirect targets that only a trap can clear.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              RAS_DEPTH    = 4
) (
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    pc_state_t       r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_fault_addr;
    logic            r_pc_valid;
    logic            r_fault;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_ras_top;
    logic            w_ras_empty;
    logic            w_use_ras;
    logic [XLEN-1:0] w_target;
    logic            w_target_ok;
    logic            w_take_redirect;
    logic            w_ras_push;
    logic            w_ras_pop;

    assign w_pc_plus4  = r_pc + XLEN'(PC_STEP);

    // A return only predicts from the stack when it actually holds something
    assign w_use_ras   = bus.redirect_is_ret && !w_ras_empty;
    assign w_target    = w_use_ras ? w_ras_top : bus.redirect_target;
    assign w_target_ok = is_aligned(w_target[1:0]);

    // The stack only moves on a redirect that is really taken: running, not pre-empted by a trap, aligned
    assign w_take_redirect = (r_state == RUN) && !bus.trap_req && bus.redirect_valid && w_target_ok;
    assign w_ras_push      = w_take_redirect && bus.redirect_is_call;
    assign w_ras_pop       = w_take_redirect && bus.redirect_is_ret;

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_ras_push),
        .i_pop       (w_ras_pop),
        .i_push_data (w_pc_plus4),
        .o_top       (w_ras_top),
        .o_empty     (w_ras_empty)
    );

    // State, PC and fault registers with registered valid/fault flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= WARMUP;
            r_pc         <= RESET_VECTOR;
            r_fault_addr <= '0;
            r_pc_valid   <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            case (r_state)
                WARMUP: begin
                    r_state    <= RUN;
                    r_pc_valid <= 1'b1;
                end
                RUN: begin
                    if (bus.trap_req) begin
                        r_pc <= TRAP_VECTOR;
                    end else if (bus.redirect_valid) begin
                        if (w_target_ok) begin
                            r_pc <= w_target;
                        end else begin
                            r_fault_addr <= w_target;
                            r_state      <= FAULT;
                            r_pc_valid   <= 1'b0;
                            r_fault      <= 1'b1;
                        end
                    end else if (!bus.stall) begin
                        r_pc <= w_pc_plus4;
                    end
                end
                FAULT: begin
                    if (bus.trap_req) begin
                        r_pc       <= TRAP_VECTOR;
                        r_state    <= RUN;
                        r_pc_valid <= 1'b1;
                        r_fault    <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= WARMUP;
                    r_pc_valid <= 1'b0;
                    r_fault    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_o         = r_pc;
    assign bus.pc_plus4_o   = w_pc_plus4;
    assign bus.pc_valid_o   = r_pc_valid;
    assign bus.fault_o      = r_fault;
    assign bus.fault_addr_o = r_fault_addr;
    assign bus.ras_empty_o  = w_ras_empty;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// run against a queue-based reference model of the sequencer.
module tb_pc_sequencer;

   localparam int          XLEN  = 32;
   localparam logic [31:0] RV    = 32'h0000_0000;
   localparam logic [31:0] TV    = 32'h0000_0100;
   localparam int          DEPTH = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   pc_sequencer_if #(.XLEN(XLEN)) bus ();

   pc_sequencer #(
      .XLEN         (XLEN),
      .RESET_VECTOR (RV),
      .TRAP_VECTOR  (TV),
      .RAS_DEPTH    (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef enum {M_WARM, M_RUN, M_FAULT} mode_t;
   mode_t       m_mode;
   logic [31:0] m_pc;
   logic [31:0] m_faddr;
   logic [31:0] m_ras[$];

   task automatic model_reset();
      m_mode  = M_WARM;
      m_pc    = RV;
      m_faddr = 32'h0;
      m_ras.delete();
   endtask

   // Advance the reference model by one clock using the inputs currently driven
   task automatic model_step();
      logic [31:0] tgt;
      logic [31:0] ret_addr;
      case (m_mode)
         M_WARM: m_mode = M_RUN;
         M_RUN: begin
            if (bus.trap_req) begin
               m_pc = TV;
            end else if (bus.redirect_valid) begin
               if (bus.redirect_is_ret && m_ras.size() > 0) tgt = m_ras[$];
               else tgt = bus.redirect_target;
               if (tgt % 4 != 0) begin
                  m_faddr = tgt;
                  m_mode  = M_FAULT;
               end else begin
                  ret_addr = m_pc + 32'd4;
                  if (bus.redirect_is_call && bus.redirect_is_ret && m_ras.size() > 0) begin
                     m_ras[m_ras.size()-1] = ret_addr;
                  end else begin
                     if (bus.redirect_is_ret && m_ras.size() > 0) void'(m_ras.pop_back());
                     if (bus.redirect_is_call) begin
                        m_ras.push_back(ret_addr);
                        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                     end
                  end
                  m_pc = tgt;
               end
            end else if (!bus.stall) begin
               m_pc = m_pc + 32'd4;
            end
         end
         M_FAULT: begin
            if (bus.trap_req) begin
               m_pc   = TV;
               m_mode = M_RUN;
            end
         end
         default: m_mode = M_WARM;
      endcase
   endtask

   function automatic logic [98:0] dut_vec();
      return {bus.pc_o, bus.pc_plus4_o, bus.pc_valid_o, bus.fault_o, bus.fault_addr_o, bus.ras_empty_o};
   endfunction

   function automatic logic [98:0] model_vec();
      logic [31:0] p4;
      p4 = m_pc + 32'd4;
      return {m_pc, p4, (m_mode == M_RUN), (m_mode == M_FAULT), m_faddr, (m_ras.size() == 0)};
   endfunction

   task automatic applyStimulus(input logic s, input logic rv, input logic [31:0] t,
                                input logic c, input logic r, input logic tr);
      bus.stall            = s;
      bus.redirect_valid   = rv;
      bus.redirect_target  = t;
      bus.redirect_is_call = c;
      bus.redirect_is_ret  = r;
      bus.trap_req         = tr;
   endtask

   // One clock: update the model, then sample 1 unit after the edge
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      applyStimulus(0, 0, 32'h0, 0, 0, 0);
      #1 reset = 1'b0;
      model_reset();
      #1;
      checks++; if (bus.pc_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected %h", bus.pc_o, 32'h0); end
      checks++; if (bus.pc_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.pc_valid_o); end
      checks++; if (bus.fault_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault: got %b expected 0", bus.fault_o); end
      checks++; if (bus.fault_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_faddr: got %h expected 0", bus.fault_addr_o); end
      checks++; if (bus.ras_empty_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ras_empty: got %b expected 1", bus.ras_empty_o); end
      @(posedge clk);
      #1 reset = 1'b1;
      checks++; if ({bus.pc_o, bus.pc_valid_o} !== {32'h0, 1'b0}) begin errors++; $display("[TB] FAIL warmup: got pc=%h v=%b expected pc=0 v=0", bus.pc_o, bus.pc_valid_o); end
      tick();
      checks++; if ({bus.pc_o, bus.pc_valid_o} !== {32'h0, 1'b1}) begin errors++; $display("[TB] FAIL run_first: got pc=%h v=%b expected pc=0 v=1", bus.pc_o, bus.pc_valid_o); end
      tick();
      checks++; if ({bus.pc_o, bus.pc_valid_o} !== {32'h4, 1'b1}) begin errors++; $display("[TB] FAIL run_seq4: got pc=%h v=%b expected pc=4 v=1", bus.pc_o, bus.pc_valid_o); end
      tick();
      checks++; if ({bus.pc_o, bus.pc_valid_o} !== {32'h8, 1'b1}) begin errors++; $display("[TB] FAIL run_seq8: got pc=%h v=%b expected pc=8 v=1", bus.pc_o, bus.pc_valid_o); end
   endtask

   task automatic test_stall_redirect();
      tick();
      tick();
      checks++; if (bus.pc_o !== 32'h10) begin errors++; $display("[TB] FAIL seq_10: got %h expected 00000010", bus.pc_o); end
      applyStimulus(1, 0, 32'h0, 0, 0, 0);
      tick();
      checks++; if (bus.pc_o !== 32'h10) begin errors++; $display("[TB] FAIL stall_hold: got %h expected 00000010", bus.pc_o); end
      applyStimulus(1, 1, 32'h40, 0, 0, 0);
      tick();
      checks++; if (bus.pc_o !== 32'h40) begin errors++; $display("[TB] FAIL redirect_over_stall: got %h expected 00000040", bus.pc_o); end
      applyStimulus(1, 0, 32'h0, 0, 0, 0);
      tick();
      checks++; if (bus.pc_o !== 32'h40) begin errors++; $display("[TB] FAIL stall_after_redirect: got %h expected 00000040", bus.pc_o); end
      applyStimulus(0, 0, 32'h0, 0, 0, 0);
   endtask

   task automatic test_call_ret();
      applyStimulus(0, 1, 32'h20, 0, 0, 0);
      tick();
      applyStimulus(0, 1, 32'h200, 1, 0, 0);
      tick();
      checks++; if ({bus.pc_o, bus.ras_empty_o} !== {32'h200, 1'b0}) begin errors++; $display("[TB] FAIL call: got pc=%h empty=%b expected pc=00000200 empty=0", bus.pc_o, bus.ras_empty_o); end
      applyStimulus(0, 1, 32'hDEAD_BEEC, 0, 1, 0);
      tick();
      checks++; if ({bus.pc_o, bus.ras_empty_o} !== {32'h24, 1'b1}) begin errors++; $display("[TB] FAIL ret: got pc=%h empty=%b expected pc=00000024 empty=1", bus.pc_o, bus.ras_empty_o); end
      applyStimulus(0, 0, 32'h0, 0, 0, 0);
   endtask

   task automatic test_ras_overflow();
      logic [31:0] exp_ret [5];
      exp_ret[0] = 32'h4004;
      exp_ret[1] = 32'h3004;
      exp_ret[2] = 32'h2004;
      exp_ret[3] = 32'h1004;
      exp_ret[4] = 32'h8000;
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(0, 1, 32'(i) * 32'h1000, 1, 0, 0);
         tick();
      end
      checks++; if ({bus.pc_o, bus.ras_empty_o} !== {32'h5000, 1'b0}) begin errors++; $display("[TB] FAIL five_calls: got pc=%h empty=%b expected pc=00005000 empty=0", bus.pc_o, bus.ras_empty_o); end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 1, 32'h8000, 0, 1, 0);
         tick();
         checks++; if (bus.pc_o !== exp_ret[i]) begin errors++; $display("[TB] FAIL ret_%0d: got %h expected %h", i, bus.pc_o, exp_ret[i]); end
      end
      checks++; if (bus.ras_empty_o !== 1'b1) begin errors++; $display("[TB] FAIL ras_drained: got %b expected 1", bus.ras_empty_o); end
      applyStimulus(0, 0, 32'h0, 0, 0, 0);
   endtask

   task automatic test_wrap();
      applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
      tick();
      checks++; if ({bus.pc_o, bus.pc_plus4_o} !== {32'hFFFF_FFFC, 32'h0}) begin errors++; $display("[TB] FAIL wrap_plus4: got pc=%h p4=%h expected pc=fffffffc p4=00000000", bus.pc_o, bus.pc_plus4_o); end
      applyStimulus(0, 0, 32'h0, 0, 0, 0);
      tick();
      checks++; if ({bus.pc_o, bus.pc_valid_o, bus.fault_o} !== {32'h0, 1'b1, 1'b0}) begin errors++; $display("[TB] FAIL wrap_pc: got pc=%h v=%b f=%b expected pc=0 v=1 f=0", bus.pc_o, bus.pc_valid_o, bus.fault_o); end
   endtask

   task automatic test_fault();
      applyStimulus(0, 1, 32'h102, 0, 0, 0);
      tick();
      checks++; if ({bus.pc_o, bus.pc_valid_o, bus.fault_o, bus.fault_addr_o} !== {32'h0, 1'b0, 1'b1, 32'h102}) begin errors++; $display("[TB] FAIL fault_entry: got pc=%h v=%b f=%b fa=%h expected pc=0 v=0 f=1 fa=00000102", bus.pc_o, bus.pc_valid_o, bus.fault_o, bus.fault_addr_o); end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'(i), 1, 32'h300, 1, 0, 0);
         tick();
         checks++; if ({bus.pc_o, bus.fault_o, bus.ras_empty_o} !== {32'h0, 1'b1, 1'b1}) begin errors++; $display("[TB] FAIL fault_frozen_%0d: got pc=%h f=%b empty=%b expected pc=0 f=1 empty=1", i, bus.pc_o, bus.fault_o, bus.ras_empty_o); end
      end
      applyStimulus(0, 0, 32'h0, 0, 0, 1);
      tick();
      checks++; if ({bus.pc_o, bus.pc_valid_o, bus.fault_o, bus.fault_addr_o} !== {32'h100, 1'b1, 1'b0, 32'h102}) begin errors++; $display("[TB] FAIL trap_exit: got pc=%h v=%b f=%b fa=%h expected pc=00000100 v=1 f=0 fa=00000102", bus.pc_o, bus.pc_valid_o, bus.fault_o, bus.fault_addr_o); end
      applyStimulus(0, 0, 32'h0, 0, 0, 0);
      tick();
      applyStimulus(1, 1, 32'h400, 1, 0, 1);
      tick();
      checks++; if ({bus.pc_o, bus.ras_empty_o} !== {32'h100, 1'b1}) begin errors++; $display("[TB] FAIL trap_over_redirect: got pc=%h empty=%b expected pc=00000100 empty=1", bus.pc_o, bus.ras_empty_o); end
      applyStimulus(0, 0, 32'h0, 0, 0, 0);
   endtask

   task automatic test_random();
      logic [31:0] t;
      applyStimulus(0, 0, 32'h0, 0, 0, 0);
      reset = 1'b0;
      model_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      checks++; if (dut_vec() !== model_vec()) begin errors++; $display("[TB] FAIL rand_start: got %h expected %h", dut_vec(), model_vec()); end
      for (int n = 0; n < 600; n++) begin
         t = $urandom;
         if ($urandom_range(9) != 0) t[1:0] = 2'b00;
         applyStimulus(($urandom_range(3) == 0), ($urandom_range(2) == 0), t,
                       ($urandom_range(2) == 0), ($urandom_range(2) == 0), ($urandom_range(19) == 0));
         tick();
         checks++; if (dut_vec() !== model_vec()) begin errors++; $display("[TB] FAIL rand_%0d: got %h expected %h", n, dut_vec(), model_vec()); end
      end
      applyStimulus(0, 0, 32'h0, 0, 0, 0);
   endtask

   task automatic test_async_reset();
      applyStimulus(0, 0, 32'h0, 0, 0, 1);
      tick();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1, 32'h500 + 32'(i) * 32'h100, 1, 0, 0);
         tick();
      end
      applyStimulus(0, 1, 32'h103, 0, 0, 0);
      tick();
      checks++; if ({bus.fault_o, bus.ras_empty_o, bus.fault_addr_o} !== {1'b1, 1'b0, 32'h103}) begin errors++; $display("[TB] FAIL pre_reset_fault: got f=%b empty=%b fa=%h expected f=1 empty=0 fa=00000103", bus.fault_o, bus.ras_empty_o, bus.fault_addr_o); end
      #3 reset = 1'b0;
      #1;
      checks++; if (dut_vec() !== {32'h0, 32'h4, 1'b0, 1'b0, 32'h0, 1'b1}) begin errors++; $display("[TB] FAIL async_reset: got %h expected %h", dut_vec(), {32'h0, 32'h4, 1'b0, 1'b0, 32'h0, 1'b1}); end
      applyStimulus(0, 0, 32'h0, 0, 0, 0);
      reset = 1'b1;
      model_reset();
      tick();
      applyStimulus(0, 1, 32'h600, 0, 1, 0);
      tick();
      checks++; if ({bus.pc_o, bus.ras_empty_o} !== {32'h600, 1'b1}) begin errors++; $display("[TB] FAIL ras_cleared: got pc=%h empty=%b expected pc=00000600 empty=1", bus.pc_o, bus.ras_empty_o); end
      applyStimulus(0, 0, 32'h0, 0, 0, 0);
   endtask

   // Scenario sequence and final summary
   initial begin
      applyStimulus(0, 0, 32'h0, 0, 0, 0);
      model_reset();
      test_reset();
      test_stall_redirect();
      test_call_ret();
      test_ras_overflow();
      test_wrap();
      test_fault();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
